// File: rtl/alloc_pkg.sv
// Shared types and constants for the allocator command sequencer.
// The ALLOC_CMD_CHECK_EN build option (used by alloc_cmd_seq) relies on BASE here.
package alloc_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'd0,
    OP_FREE  = 2'd1,
    OP_WR    = 2'd2,
    OP_RD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } stage_e;

  localparam logic [DW-1:0] UNDEF = 16'h0000;
  localparam logic [DW-1:0] NIL   = 16'h0001;
  localparam logic [DW-1:0] TRUE  = 16'h0002;
  localparam logic [DW-1:0] FALSE = 16'h0003;
  localparam logic [DW-1:0] UNIT  = 16'h0004;
  localparam logic [DW-1:0] ZERO  = 16'h8000;
  localparam logic [DW-1:0] BASE  = 16'h5000;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  // Address lies in the allocator's managed region (same top nibble as BASE).
  function automatic logic addr_in_base(input logic [DW-1:0] addr);
    return addr[DW-1:DW-4] == BASE[DW-1:DW-4];
  endfunction

endpackage

// File: rtl/alloc_rsp_fifo.sv
// Response FIFO: 17-bit entries (err + data), power-of-2 depth, registered valid and count.
module alloc_rsp_fifo
  import alloc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  rsp_t                         i_push_data,
  input  logic                         i_pop,
  output rsp_t                         o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rsp_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          valid_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = i_pop && valid_q;
  assign do_push = i_push && (count_q < CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_valid = valid_q;
  assign o_count = count_q;

endmodule

// File: rtl/alloc_cmd_seq.sv
// Allocator command sequencer: issue stage, capture stage, credit-controlled response FIFO.
// Build option ALLOC_CMD_CHECK_EN rejects FREE/WR/RD outside the BASE region.
module alloc_cmd_seq
  import alloc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [1:0]    i_cmd_op,
  input  logic [DW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_alloc,
  output logic [DW-1:0] o_adata,
  input  logic [DW-1:0] i_aaddr,
  output logic          o_free,
  output logic [DW-1:0] o_faddr,
  output logic          o_wr,
  output logic [DW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_rd,
  output logic [DW-1:0] o_raddr,
  input  logic [DW-1:0] i_rdata,
  input  logic          i_err,
  output logic          o_halted
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  stage_e        s1_state_q, s1_state_d, s2_state_q, s2_state_d;
  op_e           s1_op_q, s1_op_d, s2_op_q, s2_op_d;
  logic          s1_bad_q, s1_bad_d, s2_bad_q, s2_bad_d;
  logic          alloc_q, alloc_d, free_q, free_d, wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] adata_q, adata_d, faddr_q, faddr_d;
  logic [DW-1:0] waddr_q, waddr_d, wdata_q, wdata_d, raddr_q, raddr_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  rsp_t          fifo_head;
  rsp_t          push_entry;
  logic          push, pop, accept, cmd_bad;
  logic [1:0]    inflight;
  op_e           cmd_op;

  assign cmd_op = op_e'(i_cmd_op);

`ifdef ALLOC_CMD_CHECK_EN
  assign cmd_bad = (cmd_op != OP_ALLOC) && !addr_in_base(i_cmd_addr);
`else
  assign cmd_bad = 1'b0;
`endif

  // Credits cover entries already queued plus commands still in the two stages.
  assign inflight    = {1'b0, s1_state_q == ST_ISSUE} + {1'b0, s2_state_q == ST_CAPTURE};
  assign o_cmd_ready = !halted_q && ((SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH));
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign push        = (s2_state_q == ST_CAPTURE);
  assign pop         = fifo_valid && i_rsp_ready;

  always_comb begin
    push_entry = '0;
    if (s2_bad_q) begin
      push_entry.data = UNDEF;
      push_entry.err  = 1'b1;
    end else begin
      unique case (s2_op_q)
        OP_ALLOC: push_entry.data = i_aaddr;
        OP_RD:    push_entry.data = i_rdata;
        default:  push_entry.data = UNIT;
      endcase
      push_entry.err = i_err;
    end
  end

  // Stage advance and one-hot strobe generation for the next cycle.
  always_comb begin
    s1_state_d = ST_EMPTY;
    s1_op_d    = s1_op_q;
    s1_bad_d   = 1'b0;
    s2_state_d = ST_EMPTY;
    s2_op_d    = s2_op_q;
    s2_bad_d   = 1'b0;
    alloc_d    = 1'b0;
    free_d     = 1'b0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    adata_d    = UNDEF;
    faddr_d    = UNDEF;
    waddr_d    = UNDEF;
    wdata_d    = UNDEF;
    raddr_d    = UNDEF;
    halted_d   = halted_q | i_err;

    if (accept) begin
      s1_state_d = ST_ISSUE;
      s1_op_d    = cmd_op;
      s1_bad_d   = cmd_bad;
      if (!cmd_bad) begin
        unique case (cmd_op)
          OP_ALLOC: begin alloc_d = 1'b1; adata_d = i_cmd_data; end
          OP_FREE:  begin free_d  = 1'b1; faddr_d = i_cmd_addr; end
          OP_WR:    begin wr_d = 1'b1; waddr_d = i_cmd_addr; wdata_d = i_cmd_data; end
          default:  begin rd_d    = 1'b1; raddr_d = i_cmd_addr; end
        endcase
      end
    end

    if (s1_state_q == ST_ISSUE) begin
      s2_state_d = ST_CAPTURE;
      s2_op_d    = s1_op_q;
      s2_bad_d   = s1_bad_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_state_q <= ST_EMPTY;
      s1_op_q    <= OP_ALLOC;
      s1_bad_q   <= 1'b0;
      s2_state_q <= ST_EMPTY;
      s2_op_q    <= OP_ALLOC;
      s2_bad_q   <= 1'b0;
      alloc_q    <= 1'b0;
      free_q     <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      adata_q    <= UNDEF;
      faddr_q    <= UNDEF;
      waddr_q    <= UNDEF;
      wdata_q    <= UNDEF;
      raddr_q    <= UNDEF;
      halted_q   <= 1'b0;
    end else begin
      s1_state_q <= s1_state_d;
      s1_op_q    <= s1_op_d;
      s1_bad_q   <= s1_bad_d;
      s2_state_q <= s2_state_d;
      s2_op_q    <= s2_op_d;
      s2_bad_q   <= s2_bad_d;
      alloc_q    <= alloc_d;
      free_q     <= free_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      adata_q    <= adata_d;
      faddr_q    <= faddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      halted_q   <= halted_d;
    end
  end

  alloc_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_head      (fifo_head),
    .o_valid     (fifo_valid),
    .o_count     (fifo_count)
  );

  assign o_rsp_valid = fifo_valid;
  assign o_rsp_data  = fifo_valid ? fifo_head.data : UNDEF;
  assign o_rsp_err   = fifo_valid & fifo_head.err;
  assign o_alloc     = alloc_q;
  assign o_adata     = adata_q;
  assign o_free      = free_q;
  assign o_faddr     = faddr_q;
  assign o_wr        = wr_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_rd        = rd_q;
  assign o_raddr     = raddr_q;
  assign o_halted    = halted_q;

endmodule
